// File: rtl/result_formatter_pkg.sv
// Shared constants, types and state encoding for the decimal result formatter.
// Also provides the helper that maps a BCD digit to its ASCII code.
package result_formatter_pkg;

    localparam int NUM_DIGITS = 10;
    localparam int VALUE_W    = 32;
    localparam int CNT_W      = 6;

    typedef logic [7:0] char_t;

    localparam char_t CHAR_0  = 8'h30;
    localparam char_t CHAR_9  = 8'h39;
    localparam char_t CHAR_NL = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_EMIT    = 2'd2,
        ST_NEWLINE = 2'd3
    } state_e;

    // A well-formed double-dabble result never exceeds 9 per nibble.
    // The clamp only keeps a corrupted nibble inside the digit range.
    function automatic char_t to_ascii(input logic [3:0] digit);
        return (digit > 4'd9) ? CHAR_9 : CHAR_0 + char_t'(digit);
    endfunction

endpackage

// File: rtl/result_formatter_if.sv
// Request/stream bundle between a requester, the formatter and the byte sink.
// The master modport is the requester/sink side; the slave modport is the formatter.
interface result_formatter_if;
    import result_formatter_pkg::VALUE_W;
    import result_formatter_pkg::char_t;

    logic               start;
    logic [VALUE_W-1:0] value;
    char_t              char_out;
    logic               valid_out;
    logic               ready_in;
    logic               busy;

    modport master (
        output start,
        output value,
        output ready_in,
        input  char_out,
        input  valid_out,
        input  busy
    );

    modport slave (
        input  start,
        input  value,
        input  ready_in,
        output char_out,
        output valid_out,
        output busy
    );
endinterface

// File: rtl/result_formatter_bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one double-dabble iteration per step,
// 32 steps per conversion, with the final iteration flagged by done.
module bin2bcd_seq
    import result_formatter_pkg::VALUE_W;
    import result_formatter_pkg::CNT_W;
#(
    parameter int NUM_DIGITS = result_formatter_pkg::NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic                    step,
    input  logic [VALUE_W-1:0]      value,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [4*NUM_DIGITS-1:0] bcd_next,
    output logic                    done
);

    localparam int                BCD_W     = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(VALUE_W - 1);

    logic [VALUE_W-1:0] bin;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   adj;

    // bcd_next is exported so the caller can look at the finished result
    // on the same edge that stores it.
    always_comb begin
        // NOTE: adj receives a full default before the loop, so every bit is
        // assigned on every path and no latch is inferred.
        adj = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        bcd_next = {adj[BCD_W-2:0], bin[VALUE_W-1]};
    end

    assign done = step && (cnt == LAST_STEP);

    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments make every flop here update from
        // pre-edge values, independent of statement order.
        if (!reset_n) begin
            bin <= '0;
            bcd <= '0;
            cnt <= '0;
        end else if (load) begin
            bin <= value;
            bcd <= '0;
            cnt <= '0;
        end else if (step) begin
            bin <= {bin[VALUE_W-2:0], 1'b0};
            bcd <= bcd_next;
            cnt <= done ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/result_formatter.sv
// Prints a 32-bit unsigned value as decimal ASCII without leading zeros, followed
// by a newline, over a valid/ready byte stream.
module result_formatter
    import result_formatter_pkg::char_t;
    import result_formatter_pkg::state_e;
    import result_formatter_pkg::ST_IDLE;
    import result_formatter_pkg::ST_CONVERT;
    import result_formatter_pkg::ST_EMIT;
    import result_formatter_pkg::ST_NEWLINE;
    import result_formatter_pkg::CHAR_NL;
    import result_formatter_pkg::to_ascii;
#(
    parameter int NUM_DIGITS = result_formatter_pkg::NUM_DIGITS
) (
    input  logic              clk,
    input  logic              reset_n,
    result_formatter_if.slave bus
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int PTR_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef logic [PTR_W-1:0] ptr_t;

    state_e           state;
    state_e           state_next;
    ptr_t             ptr;
    ptr_t             ptr_next;
    ptr_t             msnz;
    char_t            char_q;
    char_t            char_next;
    logic             valid_q;
    logic             valid_next;
    logic             load;
    logic             step;
    logic             done;
    logic             xfer;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_next;

    function automatic logic [3:0] digit_at(input logic [BCD_W-1:0] b, input ptr_t p);
        logic [3:0] d;
        d = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (p == ptr_t'(i)) begin
                d = b[4*i +: 4];
            end
        end
        return d;
    endfunction

    bin2bcd_seq #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .step     (step),
        .value    (bus.value),
        .bcd      (bcd),
        .bcd_next (bcd_next),
        .done     (done)
    );

    // Leading-zero detection on the finished result; all-zero lands on
    // index 0 so that a zero value still prints a single '0'.
    always_comb begin
        msnz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'h0) begin
                msnz = ptr_t'(i);
            end
        end
    end

    assign xfer = valid_q && bus.ready_in;

    // char_out/valid_out are registered, so they hold through stalls and
    // never depend combinationally on ready_in.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        char_next  = char_q;
        valid_next = valid_q;
        load       = 1'b0;
        step       = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = ST_CONVERT;
                end
            end

            ST_CONVERT: begin
                step = 1'b1;
                if (done) begin
                    state_next = ST_EMIT;
                    ptr_next   = msnz;
                    char_next  = to_ascii(digit_at(bcd_next, msnz));
                    valid_next = 1'b1;
                end
            end

            ST_EMIT: begin
                if (xfer) begin
                    if (ptr == '0) begin
                        state_next = ST_NEWLINE;
                        char_next  = CHAR_NL;
                    end else begin
                        ptr_next  = ptr - ptr_t'(1);
                        char_next = to_ascii(digit_at(bcd, ptr - ptr_t'(1)));
                    end
                end
            end

            ST_NEWLINE: begin
                if (xfer) begin
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                end
            end

            default: begin
                state_next = ST_IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            ptr     <= '0;
            char_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            char_q  <= char_next;
            valid_q <= valid_next;
        end
    end

    assign bus.char_out  = char_q;
    assign bus.valid_out = valid_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_result_formatter.sv
// Directed and randomized checks of result_formatter against a decimal-string
// reference model built with plain division.
module tb_result_formatter;
    import result_formatter_pkg::*;

    typedef char_t char_q_t[$];

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    result_formatter_if bus ();

    result_formatter #(
        .NUM_DIGITS (10)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Decimal text of v, most-significant digit first, then newline.
    function automatic char_q_t model(input logic [31:0] v);
        char_q_t q;
        logic [31:0] r;
        r = v;
        if (r == 0) begin
            q.push_back(8'h30);
        end
        while (r != 0) begin
            q.push_front(8'h30 + char_t'(r % 10));
            r = r / 10;
        end
        q.push_back(8'h0A);
        return q;
    endfunction

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (cyc % 3) == 0;
        return 1'($urandom_range(0, 1));
    endfunction

    // mode: 0 = ready always high, 1 = 1,0,0 pattern, 2 = random ready.
    // poke: pulse start with another value during CONVERT, EMIT and the newline transfer.
    task automatic run_txn(input string tag, input logic [31:0] v, input int mode, input bit poke);
        char_q_t exp_q;
        char_q_t got;
        int      lat;
        int      cyc;
        bit      done_nl;
        bit      held;
        bit      xfer;
        char_t   held_c;
        char_t   c;

        exp_q = model(v);
        check({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);

        bus.value = v;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;

        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            bus.start = poke && (lat == 10);
            if (poke && lat == 10) bus.value = 32'd99;
            if (lat == 5) check({tag, "_busy_convert"}, {31'd0, bus.busy}, 32'd1);
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"}, lat, 32'd32);

        cyc     = 0;
        done_nl = 1'b0;
        while (!done_nl && cyc < 400) begin
            bus.ready_in = ready_for(mode, cyc);
            xfer         = bus.valid_out && bus.ready_in;
            c            = bus.char_out;
            held         = bus.valid_out && !bus.ready_in;
            held_c       = bus.char_out;
            bus.start    = poke && (cyc == 1 || (xfer && c == 8'h0A));
            if (poke) bus.value = 32'd99;
            tick();
            cyc++;
            bus.start = 1'b0;
            if (held) begin
                check({tag, "_stall_valid"}, {31'd0, bus.valid_out}, 32'd1);
                check({tag, "_stall_char"}, bus.char_out, held_c);
            end
            if (xfer) got.push_back(c);
            if (xfer && c == 8'h0A) begin
                done_nl = 1'b1;
                check({tag, "_busy_after_nl"}, {31'd0, bus.busy}, 32'd0);
                check({tag, "_valid_after_nl"}, {31'd0, bus.valid_out}, 32'd0);
            end
        end
        check({tag, "_completed"}, {31'd0, done_nl}, 32'd1);

        if (mode == 0) check({tag, "_no_bubble"}, cyc, exp_q.size());
        check({tag, "_length"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_char%0d", tag, i), got[i], exp_q[i]);
        end

        if (poke) begin
            tick();
            tick();
            check({tag, "_start_ignored"}, {31'd0, bus.busy}, 32'd0);
        end
    endtask

    initial begin
        char_t c1;
        char_t c2;
        int    lat;
        bit    any_valid;
        logic [31:0] r;
        int unsigned w;

        checks       = 0;
        errors       = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.value    = '0;
        bus.ready_in = 1'b0;

        #12;
        check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_char", {24'd0, bus.char_out}, 32'h00);

        @(posedge clk);
        #1 reset_n = 1'b1;

        run_txn("zero", 32'd0, 0, 1'b0);
        run_txn("v357", 32'd357, 0, 1'b0);
        run_txn("vmax", 32'hFFFF_FFFF, 0, 1'b0);
        run_txn("v1000", 32'd1000, 1, 1'b0);
        run_txn("v42", 32'd42, 0, 1'b1);

        // Reset in the middle of streaming 12345.
        bus.value    = 32'd12345;
        bus.start    = 1'b1;
        bus.ready_in = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (!bus.valid_out && lat < 100) begin
            tick();
            lat++;
        end
        check("rst_mid_latency", lat, 32'd32);
        c1 = bus.char_out;
        tick();
        c2 = bus.char_out;
        tick();
        check("rst_mid_c1", {24'd0, c1}, 32'h31);
        check("rst_mid_c2", {24'd0, c2}, 32'h32);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'd0, bus.valid_out}, 32'd0);
        check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        any_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.valid_out) any_valid = 1'b1;
        end
        check("rst_no_output", {31'd0, any_valid}, 32'd0);
        run_txn("v7", 32'd7, 0, 1'b0);

        for (int n = 0; n < 16; n++) begin
            w = $urandom_range(1, 32);
            r = $urandom;
            if (w < 32) r = r & ((32'h1 << w) - 32'h1);
            run_txn($sformatf("rand%0d", n), r, 2, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_formatter.md
RESULT_FORMATTER -- requirements
Module: result_formatter

Interface
REQ-001 Parameter NUM_DIGITS, default 10: decimal digit capacity; it SHALL cover a full 32-bit value.
REQ-002 clk  input  1  single clock; all flops rise-edge triggered.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to format value; sampled only in IDLE.
REQ-005 value  input  32  unsigned binary total to print, sampled on the accepted start edge.
REQ-006 char_out  output  8  ASCII character to the downstream byte sink.
REQ-007 valid_out  output  1  char_out holds a valid character.
REQ-008 ready_in  input  1  downstream accepts char_out this cycle.
REQ-009 busy  output  1  high in every state except IDLE.

Function
REQ-010 The block SHALL convert value to decimal and stream it MSB-first as ASCII ('0'=0x30 + digit), then one newline (0x0A).
REQ-011 Leading zeros SHALL be suppressed; value 0 SHALL emit exactly "0" then 0x0A.
REQ-012 States SHALL be IDLE, CONVERT, EMIT, NEWLINE.
REQ-013 IDLE->CONVERT on start: latch value, clear the BCD register, clear the shift counter.
REQ-014 CONVERT: one double-dabble iteration per cycle (add 3 to each BCD nibble >= 5, then shift left 1 with the binary MSB entering).
REQ-015 CONVERT SHALL last exactly 32 cycles; valid_out SHALL first be high 32 edges after the edge that accepted start.
REQ-016 On leaving CONVERT, the digit pointer SHALL load the index of the most-significant non-zero nibble, or index 0 if all nibbles are zero.
REQ-017 A transfer SHALL occur on a rising edge where valid_out and ready_in are both high.
REQ-018 EMIT: on each transfer, decrement the pointer; the transfer of digit index 0 SHALL move the block to NEWLINE.
REQ-019 NEWLINE: char_out=0x0A with valid_out high; its transfer SHALL return the block to IDLE.
REQ-020 While valid_out is high and ready_in is low, char_out and valid_out SHALL hold stable.
REQ-021 valid_out SHALL NOT depend combinationally on ready_in.
REQ-022 With ready_in held high, one character SHALL transfer per cycle with no bubbles.
REQ-023 start while busy SHALL be ignored, and value SHALL NOT be re-sampled.
REQ-024 start in the same cycle as the final newline transfer SHALL be ignored; start is accepted only in IDLE.
REQ-025 The BCD register SHALL be 4*NUM_DIGITS bits; the shift counter SHALL be 6 bits, counting 0..31.
REQ-026 valid_out SHALL be low in IDLE and CONVERT.
REQ-027 char_out is don't-care when valid_out is low, but SHALL be driven (no X after reset).

Reset
REQ-028 reset_n low SHALL asynchronously force: state=IDLE, valid_out=0, busy=0, char_out=0x00, BCD register=0, counter=0, pointer=0.
REQ-029 Reset asserted mid-CONVERT or mid-EMIT SHALL abort the output; no further characters SHALL appear after deassertion until a new start.
REQ-030 Deassertion of reset_n is synchronised externally; the block SHALL accept start on the first cycle after deassertion.

Structure
REQ-031 A shared package SHALL hold CHAR_0 (0x30), CHAR_9 (0x39), CHAR_NL (0x0A), NUM_DIGITS, and the state encoding.
REQ-032 Sub-module bin2bcd_seq SHALL contain the latch, 32-cycle double-dabble iteration and done flag.
REQ-033 result_formatter SHALL contain the FSM, leading-zero detection, pointer and handshake.

Verification
REQ-034 value=0, ready_in=1: output "0",0x0A (0x30,0x0A); valid_out first high 32 cycles after start; busy low the cycle after the newline transfer.
REQ-035 value=357, ready_in=1: output 0x33,0x35,0x37,0x0A on 4 consecutive cycles.
REQ-036 value=0xFFFFFFFF: output "4294967295" then 0x0A, 11 transfers total.
REQ-037 value=1000, ready_in toggling 1,0,0,1,...: char_out stable across stalls; sequence 0x31,0x30,0x30,0x30,0x0A, no loss or duplication.
REQ-038 value=42 in flight; start with value=99 pulsed during CONVERT and during EMIT: only "42",0x0A is output.
REQ-039 value=12345; reset_n pulsed low after "12" transferred: valid_out drops immediately and stays low; a new start with value=7 yields 0x37,0x0A.
